// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD-to-decimal decoder.
package bcd_pkg;

  // Controller states: waiting for a word, or streaming its digits out.
  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Largest legal BCD digit value; anything above is an invalid nibble.
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Width of the one-hot decimal code.
  localparam int DEC_W = 10;

endpackage

// File: rtl/bcd_digit_decoder.sv
// Combinational decode of one BCD nibble into a 10-bit one-hot decimal code.
// Values 0..9 set bit <value>; values 10..15 give an all-zero code plus o_err.
module bcd_digit_decoder
  import bcd_pkg::*;
(
  input  logic [3:0]       i_nib,
  output logic [DEC_W-1:0] o_dec,
  output logic             o_err
);

  localparam logic [DEC_W-1:0] DEC_ONE = DEC_W'(1);

  // One-hot decode with invalid-nibble detection.
  always_comb begin
    o_dec = '0;
    o_err = 1'b0;
    if (i_nib > BCD_MAX) begin
      o_err = 1'b1;
    end else begin
      o_dec = DEC_ONE << i_nib;
    end
  end

endmodule

// File: rtl/bcd_to_dec_decoder.sv
// Serial BCD-to-decimal decoder: captures a packed BCD word and emits one
// one-hot decimal code per digit, most-significant digit first.
// Optional macro BCD_LZB_EN: leading-zero suppression (start at the highest
// nonzero nibble; an all-zero word emits a single digit 0).
//
// Handshakes: both streams use valid/ready. A transfer happens on a rising
// clk edge where valid and ready are both high. in_ready is high only in
// IDLE; out_valid is high only in EMIT. Every output is decoded from
// registered state alone, so outputs hold steady while out_ready is low.
module bcd_to_dec_decoder
  import bcd_pkg::*;
#(
  parameter  int DIGITS = 4,
  localparam int IDXW   = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEC_W-1:0]      out_dec,
  output logic [IDXW-1:0]       out_idx,
  output logic                  out_last,
  output logic                  out_err,
  output logic                  word_err
);

  state_t                r_state;
  state_t                w_state_next;
  logic [4*DIGITS-1:0]   r_word;
  logic [IDXW-1:0]       r_idx;
  logic                  r_acc;

  logic                  w_emit;
  logic                  w_in_fire;
  logic                  w_out_fire;
  logic [3:0]            w_nib;
  logic [DEC_W-1:0]      w_dec;
  logic                  w_err;
  logic [IDXW-1:0]       w_start;

  assign w_emit     = (r_state == EMIT);
  assign w_in_fire  = in_valid && !w_emit;
  assign w_out_fire = w_emit && out_ready;

  // Nibble currently addressed by the digit index.
  assign w_nib = r_word[{r_idx, 2'b00} +: 4];

  bcd_digit_decoder u_digit (
    .i_nib (w_nib),
    .o_dec (w_dec),
    .o_err (w_err)
  );

`ifdef BCD_LZB_EN
  // Start at the highest nonzero nibble; invalid nibbles count as nonzero.
  always_comb begin
    w_start = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (in_bcd[4*k +: 4] != 4'd0) begin
        w_start = IDXW'(k);
      end
    end
  end
`else
  assign w_start = IDXW'(DIGITS - 1);
`endif

  // Next-state: leave IDLE on word capture, leave EMIT after the final digit.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_in_fire) w_state_next = EMIT;
      EMIT:    if (w_out_fire && (r_idx == '0)) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State, word, digit index and error accumulator registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_word  <= '0;
      r_idx   <= '0;
      r_acc   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_in_fire) begin
        r_word <= in_bcd;
        r_idx  <= w_start;
        r_acc  <= 1'b0;
      end else if (w_out_fire && (r_idx != '0)) begin
        r_idx <= r_idx - 1'b1;
        r_acc <= r_acc | w_err;
      end
    end
  end

  assign in_ready  = !w_emit;
  assign out_valid = w_emit;
  assign out_dec   = w_emit ? w_dec : '0;
  assign out_idx   = w_emit ? r_idx : '0;
  assign out_last  = w_emit && (r_idx == '0);
  assign out_err   = w_emit && w_err;
  assign word_err  = w_emit && (r_acc || w_err);

endmodule

// File: doc/bcd_to_dec_decoder.md
# bcd_to_dec_decoder

Serial BCD-to-decimal decoder: accepts a packed multi-digit BCD word over a valid/ready handshake and emits one 10-bit one-hot decimal code per digit, most-significant digit first, on a second valid/ready stream. It is the inverse of the decimal-to-BCD encoder. It sits between arithmetic blocks producing packed BCD and display or scan logic that consumes one-hot digit selects. Invalid nibbles (4'hA–4'hF) are flagged per digit and per word.

## Interface
- DIGITS, 4, number of BCD digits per input word (legal 1..8)
- IDXW, max(1,$clog2(DIGITS)), width of digit index (derived, not overridden)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word
- in_bcd  in  4*DIGITS  packed BCD; digit k = in_bcd[4k+3:4k], digit 0 least significant
- out_valid  out  1  digit output valid
- out_ready  in  1  consumer accepts digit
- out_dec  out  10  one-hot decimal; bit n set for value n; all-zero when invalid or out_valid=0
- out_idx  out  IDXW  position of the presented digit
- out_last  out  1  presented digit is final digit of the word
- out_err  out  1  presented nibble is ≥ 4'hA
- word_err  out  1  OR of out_err over all digits of the word emitted so far, including current

## Operation
- FSM states: IDLE, EMIT.
- IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, capture in_bcd into word register, set idx to start index (DIGITS-1, or per BCD_LZB_EN), clear error accumulator, go to EMIT.
- EMIT: in_ready=0, out_valid=1. out_dec/out_err decode nibble idx of registered word. Digit transfer = out_valid&&out_ready.
- On transfer with idx≠0: idx decrements, accumulator ORs in out_err.
- On transfer with idx=0: return to IDLE.
- out_last=1 iff EMIT and idx=0.
- Decode: nibble 0..9 → out_dec=1<<value, out_err=0; nibble 10..15 → out_dec=0, out_err=1.
- in_valid during EMIT is ignored (not captured); producer must hold it until in_ready.
- Reset mid-word aborts; remaining digits are never emitted.

## Timing
- Reset values: in_ready=1, out_valid=0, out_dec=0, out_idx=0, out_last=0, out_err=0, word_err=0; state IDLE.
- Word accepted at edge N → first digit valid in cycle N+1.
- No combinational path from in_* or out_ready to any output except through registered state.
- Outputs stable while out_valid=1 and out_ready=0.
- Throughput with out_ready held high: one word per (emitted digits + 1) cycles; one IDLE cycle between words.

## Configuration
- BCD_LZB_EN defined: leading-zero suppression. On capture, start index = highest digit position holding a nonzero nibble (invalid nibbles count as nonzero); all-zero word starts at idx 0 and emits one digit, value 0. out_idx still reports true position.
- Undefined: all DIGITS digits are emitted for every word, start index DIGITS-1.

## Structure
- Package bcd_pkg: state enum typedef (IDLE, EMIT), BCD_MAX=4'd9 constant, 10-bit one-hot width constant.
- Sub-module bcd_digit_decoder: combinational 4-bit nibble → out_dec[9:0] and err; instantiated once on the selected nibble.

## Test plan
- DIGITS=4, in_bcd=16'h1937, out_ready=1 → out_dec 10'h002, 10'h200, 10'h008, 10'h080 on cycles N+1..N+4; out_idx 3,2,1,0; out_last only on 4th; word_err=0; in_ready=1 at N+5.
- Same word, out_ready low 3 cycles while digit idx 2 presented → out_dec=10'h200, out_idx=2 held stable; no digit skipped or duplicated.
- in_bcd=16'h12A4 → idx1 out_dec=0, out_err=1; word_err=1 on idx1 and idx0; next word 16'h0000 → word_err=0 throughout.
- in_valid held high with new word while EMIT → in_ready=0, word not captured; captured on first IDLE cycle, its first digit follows next cycle.
- rst asserted after 2 of 4 digits → out_valid=0 and in_ready=1 immediately; next word begins at out_idx 3.
- BCD_LZB_EN: 16'h0042 → two digits (idx1 10'h010, idx0 10'h004, last on idx0); 16'h0000 → one digit idx0, 10'h001, out_last=1; 16'h0B00 → first digit idx2, out_err=1.
